// File: rtl/scope_capture_ctrl_if.sv
// ADC sample stream and sample-RAM write/read port bundle.
// The controller is the master: it consumes samples and drives the RAM.
interface scope_capture_ctrl_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 10
) ();
   logic [DATA_W-1:0] adc_data;
   logic              adc_valid;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_we;
   logic [DATA_W-1:0] ram_wdata;

   modport master (
      input  adc_data,
      input  adc_valid,
      output ram_addr,
      output ram_we,
      output ram_wdata
   );

   modport slave (
      output adc_data,
      output adc_valid,
      input  ram_addr,
      input  ram_we,
      input  ram_wdata
   );
endinterface

// File: rtl/scope_capture_ctrl.sv
// Scope capture sequencer: sample FIFO, rising-edge trigger FSM and
// arbitration of the single-port sample RAM against the display reader.
module scope_capture_ctrl #(
   parameter int DATA_W     = 8,
   parameter int SAMPLES    = 640,
   parameter int ADDR_W     = 10,
   parameter int FIFO_DEPTH = 16,
   parameter int H_VISIBLE  = 640,
   parameter int V_VISIBLE  = 480
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [10:0]                hcounter,
   input  logic [9:0]                 vcounter,
   input  logic [DATA_W-1:0]          trig_level,
   input  logic                       arm,
   input  logic                       auto_rearm,
   scope_capture_ctrl_if.master       bus,
   output logic [1:0]                 state,
   output logic                       overflow,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0]    DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);
   localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(SAMPLES - 1);
   localparam logic [10:0]       H_VIS   = 11'(H_VISIBLE);
   localparam logic [9:0]        V_VIS   = 10'(V_VISIBLE);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARMED   = 2'd1,
      S_CAPTURE = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t            st;
   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] prev;
   logic              prev_valid;

   logic              display_busy;
   logic              full;
   logic              empty;
   logic              push;
   logic              pop;
   logic              trig;
   logic              rearm;
   logic              wr_hit;
   logic [DATA_W-1:0] head;

   assign display_busy = (vcounter < V_VIS) && (hcounter < H_VIS);
   assign full  = (fifo_level == DEPTH_C);
   assign empty = (fifo_level == '0);
   assign push  = bus.adc_valid && !full;
   // Every RAM-free cycle consumes a sample; IDLE/DONE simply discard it.
   assign pop   = !display_busy && !empty;
   assign head  = mem[rd_ptr];
   assign trig  = prev_valid && (prev < trig_level) && (head >= trig_level);
   assign rearm = arm || ((st == S_DONE) && auto_rearm &&
                          (hcounter == '0) && (vcounter == '0));
   // A sample popped in the same cycle as arm belongs to the abandoned run.
   assign wr_hit = pop && !arm &&
                   (((st == S_ARMED) && trig) || (st == S_CAPTURE));

   assign bus.ram_we    = wr_hit && !reset;
   assign bus.ram_addr  = display_busy ? hcounter[ADDR_W-1:0] : wr_addr;
   assign bus.ram_wdata = head;
   assign state         = st;

   // FIFO storage: written on every accepted sample, no reset needed.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.adc_data;
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         fifo_level <= fifo_level + {{PTR_W{1'b0}}, push}
                                  - {{PTR_W{1'b0}}, pop};
      end
   end

   // Trigger/capture FSM with write address, previous sample and overflow flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         st         <= S_IDLE;
         wr_addr    <= '0;
         prev       <= '0;
         prev_valid <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         if (rearm) begin
            st         <= S_ARMED;
            wr_addr    <= '0;
            prev_valid <= 1'b0;
         end else if (pop) begin
            unique case (st)
               S_ARMED: begin
                  if (trig) begin
                     st      <= S_CAPTURE;
                     wr_addr <= ADDR_W'(1);
                  end else begin
                     prev       <= head;
                     prev_valid <= 1'b1;
                  end
               end
               S_CAPTURE: begin
                  if (wr_addr == LAST) begin
                     st      <= S_DONE;
                     wr_addr <= '0;
                  end else begin
                     wr_addr <= wr_addr + ADDR_W'(1);
                  end
               end
               S_IDLE, S_DONE: ;
            endcase
         end
         if (bus.adc_valid && full) overflow <= 1'b1;
         else if (rearm)            overflow <= 1'b0;
      end
   end
endmodule

// File: tb/tb_scope_capture_ctrl.sv
// Self-checking bench for scope_capture_ctrl: scenario tasks compare the
// RAM write stream against a trigger/capture reference model.
module tb_scope_capture_ctrl;
   localparam int SAMPLES = 640;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [10:0] hcounter = '0;
   logic [9:0]  vcounter = '0;
   logic [7:0]  trig_level = '0;
   logic       arm = 1'b0;
   logic       auto_rearm = 1'b0;
   logic [1:0] state;
   logic       overflow;
   logic [4:0] fifo_level;

   scope_capture_ctrl_if bus ();

   scope_capture_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .hcounter   (hcounter),
      .vcounter   (vcounter),
      .trig_level (trig_level),
      .arm        (arm),
      .auto_rearm (auto_rearm),
      .bus        (bus.master),
      .state      (state),
      .overflow   (overflow),
      .fifo_level (fifo_level)
   );

   int n_cmp = 0;
   int n_err = 0;
   bit free_run = 1'b0;
   int busy_cycles = 0;
   int busy_viol = 0;
   int wq_addr[$];
   int wq_data[$];
   int stream[$];

   always #5 clk = ~clk;

   // Log RAM writes and display-priority violations away from the clock edge.
   always @(negedge clk) begin
      if (vcounter < 10'd480 && hcounter < 11'd640) begin
         busy_cycles++;
         if (bus.ram_we !== 1'b0 || bus.ram_addr !== hcounter[9:0])
            busy_viol++;
      end
      if (bus.ram_we === 1'b1) begin
         wq_addr.push_back(int'(bus.ram_addr));
         wq_data.push_back(int'(bus.ram_wdata));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (free_run) begin
         if (hcounter == 11'd799) begin
            hcounter = '0;
            if (int'(vcounter) + 12 >= 525) vcounter = '0;
            else vcounter = vcounter + 10'd12;
         end else begin
            hcounter = hcounter + 11'd1;
         end
      end
   endtask

   // Reference model: index of the first sample that fires a rising
   // crossing of t relative to the sample before it, or -1.
   function automatic int find_trig(input int s[$], input int t);
      for (int i = 1; i < s.size(); i++)
         if (s[i-1] < t && s[i] >= t) return i;
      return -1;
   endfunction

   task automatic capture_fast(input int t, input bit dense,
                               input int stop, output bit timed_out);
      int v;
      free_run = 1'b0;
      hcounter = 11'd700;
      vcounter = '0;
      trig_level = t[7:0];
      bus.adc_valid = 1'b0;
      timed_out = 1'b1;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (fifo_level == 5'd0) break;
      end
      wq_addr.delete();
      wq_data.delete();
      stream.delete();
      arm = 1'b1;
      tick();
      arm = 1'b0;
      for (int c = 0; c < 8000; c++) begin
         tick();
         if (state == 2'd3 || wq_addr.size() >= stop) begin
            timed_out = 1'b0;
            break;
         end
         bus.adc_valid = dense || ($urandom_range(0, 2) != 0);
         if (bus.adc_valid) begin
            v = int'($urandom_range(0, 255));
            bus.adc_data = v[7:0];
            stream.push_back(v);
         end
      end
      bus.adc_valid = 1'b0;
   endtask

   task automatic test_reset();
      free_run = 1'b0;
      reset = 1'b1;
      hcounter = 11'd100;
      vcounter = 10'd10;
      repeat (3) tick();
      reset = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (state !== 2'd0) begin
         n_err++;
         $display("FAIL reset_state: got %0d expected 0", state);
      end
      n_cmp++;
      if (bus.ram_we !== 1'b0) begin
         n_err++;
         $display("FAIL reset_we: got %b expected 0", bus.ram_we);
      end
      n_cmp++;
      if (fifo_level !== 5'd0) begin
         n_err++;
         $display("FAIL reset_level: got %0d expected 0", fifo_level);
      end
      n_cmp++;
      if (overflow !== 1'b0) begin
         n_err++;
         $display("FAIL reset_ovf: got %b expected 0", overflow);
      end
      n_cmp++;
      if (bus.ram_addr !== 10'd100) begin
         n_err++;
         $display("FAIL reset_addr: got %0d expected 100", bus.ram_addr);
      end
   endtask

   task automatic test_overflow();
      int exp_lvl;
      int drained;
      bit exp_ovf;
      trig_level = 8'd255;
      hcounter = 11'd100;
      vcounter = 10'd10;
      tick();
      arm = 1'b1;
      tick();
      arm = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 20; k++) begin
         bus.adc_valid = 1'b1;
         bus.adc_data = 8'(k);
         tick();
         bus.adc_valid = 1'b0;
         @(negedge clk);
         exp_lvl = (k + 1 > 16) ? 16 : k + 1;
         exp_ovf = (k + 1 > 16);
         n_cmp++;
         if (int'(fifo_level) != exp_lvl || overflow !== exp_ovf) begin
            n_err++;
            $display("FAIL ovf_fill[%0d]: got level %0d ovf %b expected %0d %b",
                     k, fifo_level, overflow, exp_lvl, exp_ovf);
         end
      end
      repeat (5) begin
         tick();
         @(negedge clk);
         n_cmp++;
         if (overflow !== 1'b1 || fifo_level !== 5'd16) begin
            n_err++;
            $display("FAIL ovf_hold: got ovf %b level %0d expected 1 16",
                     overflow, fifo_level);
         end
      end
      hcounter = 11'd700;
      drained = -1;
      for (int c = 1; c <= 40; c++) begin
         tick();
         @(negedge clk);
         if (fifo_level == 5'd0) begin
            drained = c;
            break;
         end
      end
      n_cmp++;
      if (drained != 16) begin
         n_err++;
         $display("FAIL ovf_drain: got %0d cycles expected 16", drained);
      end
      n_cmp++;
      if (state !== 2'd1 || overflow !== 1'b1) begin
         n_err++;
         $display("FAIL ovf_after_drain: got state %0d ovf %b expected 1 1",
                  state, overflow);
      end
      arm = 1'b1;
      tick();
      arm = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (overflow !== 1'b0 || state !== 2'd1) begin
         n_err++;
         $display("FAIL ovf_arm_clear: got ovf %b state %0d expected 0 1",
                  overflow, state);
      end
   endtask

   task automatic test_ramp_capture();
      bit done;
      int k;
      int idx;
      done = 1'b0;
      k = 0;
      free_run = 1'b0;
      hcounter = '0;
      vcounter = '0;
      trig_level = 8'd100;
      auto_rearm = 1'b0;
      bus.adc_valid = 1'b0;
      wq_addr.delete();
      wq_data.delete();
      stream.delete();
      busy_cycles = 0;
      busy_viol = 0;
      free_run = 1'b1;
      arm = 1'b1;
      tick();
      arm = 1'b0;
      for (int c = 0; c < 60000; c++) begin
         tick();
         if (wq_addr.size() >= SAMPLES) begin
            done = 1'b1;
            break;
         end
         if (c % 50 == 0) begin
            bus.adc_valid = 1'b1;
            bus.adc_data = 8'(k % 256);
            stream.push_back(k % 256);
            k++;
         end else begin
            bus.adc_valid = 1'b0;
         end
      end
      bus.adc_valid = 1'b0;
      n_cmp++;
      if (!done) begin
         n_err++;
         $display("FAIL ramp_timeout: got %0d writes expected %0d",
                  wq_addr.size(), SAMPLES);
      end
      n_cmp++;
      if (state !== 2'd3) begin
         n_err++;
         $display("FAIL ramp_done_state: got %0d expected 3", state);
      end
      if (done) begin
         n_cmp++;
         if (wq_addr[0] != 0 || wq_data[0] != 100) begin
            n_err++;
            $display("FAIL ramp_first: got addr %0d data %0d expected 0 100",
                     wq_addr[0], wq_data[0]);
         end
         n_cmp++;
         if (wq_addr[1] != 1 || wq_data[1] != 101) begin
            n_err++;
            $display("FAIL ramp_addr1: got addr %0d data %0d expected 1 101",
                     wq_addr[1], wq_data[1]);
         end
         n_cmp++;
         if (wq_addr[155] != 155 || wq_data[155] != 255) begin
            n_err++;
            $display("FAIL ramp_addr155: got addr %0d data %0d expected 155 255",
                     wq_addr[155], wq_data[155]);
         end
         n_cmp++;
         if (wq_addr[156] != 156 || wq_data[156] != 0) begin
            n_err++;
            $display("FAIL ramp_addr156: got addr %0d data %0d expected 156 0",
                     wq_addr[156], wq_data[156]);
         end
         idx = find_trig(stream, 100);
         for (int a = 0; a < SAMPLES; a++) begin
            n_cmp++;
            if (wq_addr[a] != a || wq_data[a] != stream[idx + a]) begin
               n_err++;
               $display("FAIL ramp_model[%0d]: got addr %0d data %0d expected %0d %0d",
                        a, wq_addr[a], wq_data[a], a, stream[idx + a]);
            end
         end
      end
      free_run = 1'b0;
      repeat (100) tick();
      n_cmp++;
      if (wq_addr.size() != SAMPLES) begin
         n_err++;
         $display("FAIL ramp_total: got %0d writes expected %0d",
                  wq_addr.size(), SAMPLES);
      end
      n_cmp++;
      if (overflow !== 1'b0) begin
         n_err++;
         $display("FAIL ramp_ovf: got %b expected 0", overflow);
      end
      n_cmp++;
      if (busy_viol != 0 || busy_cycles == 0) begin
         n_err++;
         $display("FAIL display_priority: got %0d violations in %0d busy cycles expected 0",
                  busy_viol, busy_cycles);
      end
   endtask

   task automatic test_random_capture();
      bit to;
      int t;
      int idx;
      for (int r = 0; r < 2; r++) begin
         t = int'($urandom_range(32, 224));
         capture_fast(t, 1'b0, 100000, to);
         repeat (20) tick();
         idx = find_trig(stream, t);
         n_cmp++;
         if (to || state !== 2'd3 || idx < 0 ||
             stream.size() < idx + SAMPLES || wq_addr.size() != SAMPLES) begin
            n_err++;
            $display("FAIL rand_run[%0d]: got state %0d writes %0d trig %0d expected 3 %0d",
                     r, state, wq_addr.size(), idx, SAMPLES);
         end else begin
            for (int a = 0; a < SAMPLES; a++) begin
               n_cmp++;
               if (wq_addr[a] != a || wq_data[a] != stream[idx + a]) begin
                  n_err++;
                  $display("FAIL rand_model[%0d]: got addr %0d data %0d expected %0d %0d",
                           a, wq_addr[a], wq_data[a], a, stream[idx + a]);
               end
            end
         end
      end
   endtask

   task automatic test_auto_rearm();
      bit to;
      capture_fast(int'($urandom_range(32, 224)), 1'b1, 100000, to);
      n_cmp++;
      if (to || state !== 2'd3) begin
         n_err++;
         $display("FAIL rearm_setup: got state %0d expected 3", state);
      end
      auto_rearm = 1'b1;
      hcounter = 11'd5;
      vcounter = '0;
      repeat (3) begin
         tick();
         @(negedge clk);
         n_cmp++;
         if (state !== 2'd3) begin
            n_err++;
            $display("FAIL rearm_wait: got %0d expected 3", state);
         end
      end
      tick();
      hcounter = '0;
      vcounter = '0;
      @(negedge clk);
      n_cmp++;
      if (state !== 2'd3) begin
         n_err++;
         $display("FAIL rearm_at_origin: got %0d expected 3", state);
      end
      tick();
      hcounter = 11'd1;
      @(negedge clk);
      n_cmp++;
      if (state !== 2'd1) begin
         n_err++;
         $display("FAIL rearm_auto: got %0d expected 1", state);
      end
      auto_rearm = 1'b0;
      capture_fast(int'($urandom_range(32, 224)), 1'b1, 100000, to);
      n_cmp++;
      if (to || state !== 2'd3) begin
         n_err++;
         $display("FAIL norearm_setup: got state %0d expected 3", state);
      end
      for (int f = 0; f < 3; f++) begin
         tick();
         hcounter = '0;
         vcounter = '0;
         repeat (4) begin
            tick();
            hcounter = 11'd700;
            vcounter = 10'd500;
            @(negedge clk);
            n_cmp++;
            if (state !== 2'd3) begin
               n_err++;
               $display("FAIL norearm_frame[%0d]: got %0d expected 3", f, state);
            end
         end
      end
      tick();
      arm = 1'b1;
      tick();
      arm = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (state !== 2'd1) begin
         n_err++;
         $display("FAIL norearm_arm: got %0d expected 1", state);
      end
   endtask

   task automatic test_reset_mid_capture();
      bit to;
      int t;
      int idx;
      capture_fast(int'($urandom_range(32, 224)), 1'b1, 300, to);
      n_cmp++;
      if (to || state !== 2'd2 || wq_addr.size() != 300) begin
         n_err++;
         $display("FAIL midrst_setup: got state %0d writes %0d expected 2 300",
                  state, wq_addr.size());
      end
      reset = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (bus.ram_we !== 1'b0) begin
         n_err++;
         $display("FAIL midrst_we: got %b expected 0", bus.ram_we);
      end
      tick();
      reset = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (state !== 2'd0 || fifo_level !== 5'd0 || overflow !== 1'b0) begin
         n_err++;
         $display("FAIL midrst_values: got state %0d level %0d ovf %b expected 0 0 0",
                  state, fifo_level, overflow);
      end
      t = int'($urandom_range(32, 224));
      capture_fast(t, 1'b1, 100000, to);
      repeat (20) tick();
      idx = find_trig(stream, t);
      n_cmp++;
      if (to || idx < 0 || stream.size() < idx + SAMPLES ||
          wq_addr.size() != SAMPLES) begin
         n_err++;
         $display("FAIL midrst_rerun: got writes %0d trig %0d expected %0d",
                  wq_addr.size(), idx, SAMPLES);
      end else begin
         n_cmp++;
         if (wq_addr[0] != 0 || wq_data[0] != stream[idx]) begin
            n_err++;
            $display("FAIL midrst_first: got addr %0d data %0d expected 0 %0d",
                     wq_addr[0], wq_data[0], stream[idx]);
         end
         for (int a = 0; a < SAMPLES; a++) begin
            n_cmp++;
            if (wq_addr[a] != a || wq_data[a] != stream[idx + a]) begin
               n_err++;
               $display("FAIL midrst_model[%0d]: got addr %0d data %0d expected %0d %0d",
                        a, wq_addr[a], wq_data[a], a, stream[idx + a]);
            end
         end
      end
   endtask

   initial begin
      bus.adc_valid = 1'b0;
      bus.adc_data = '0;
      test_reset();
      test_overflow();
      test_ramp_capture();
      test_random_capture();
      test_auto_rearm();
      test_reset_mid_capture();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
